mod_pow2_scale_seq: RTL
=======================

// Module: mod_pow2_scale_seq
// PURPOSE
//   Iterative modular scaler: computes y = x * 2^(-k) mod Q (halve mode) or y = x * 2^k mod Q
//   (double mode), one halving/doubling step per clock. Successor to the single-step
//   combinational mod-Q halver.
//   Used after the Kyber INTT for the 128^-1 (2^-7) scaling and for generic power-of-two
//   rescaling in the multiplier datapath. Valid/ready on both sides; a tag travels with each operand.
// PARAMETERS
//   Q     3329  odd modulus
//   W     12    operand width; 2^W <= 2*Q must hold
//   KMAX  7     maximum step count accepted
//   KW    3     width of in_k, ceil(log2(KMAX+1))
//   TW    4     width of the sideband tag
// PORTS
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous, active-high reset
//   in_valid  in   1   operand offered
//   in_ready  out  1   block can accept an operand this cycle
//   in_x      in   W   operand; any value < 2*Q
//   in_k      in   KW  step count, 0..KMAX
//   in_dir    in   1   0 = halve (2^-k), 1 = double (2^k)
//   in_tag    in   TW  sideband, returned unchanged with the result
//   out_valid out  1   result available
//   out_ready in   1   consumer takes the result this cycle
//   out_y     out  W   result, always in [0,Q)
//   out_tag   out  TW  tag of the operand that produced out_y
//   busy      out  1   high in BUSY state
// BEHAVIOUR
//   Reset: state=IDLE; out_valid=0, out_y=0, out_tag=0, busy=0. in_ready=0 while rst=1.
//   Reset takes priority over everything, including mid-BUSY and DONE; the in-flight op is discarded.
//   FSM states: IDLE, BUSY, DONE.
//     in_ready = (state==IDLE) | (state==DONE & out_ready).
//   Accept (in_valid & in_ready):
//     r <= (in_x >= Q) ? in_x - Q : in_x;  cnt <= in_k;  dir, tag latched.
//     Next state is BUSY if in_k != 0, otherwise DONE.
//   BUSY: each cycle r <= step(r) and cnt <= cnt-1. When cnt==1 the next state is DONE.
//   Halve step: r odd  -> (r>>1) + (Q+1)/2;  r even -> r>>1.
//     The result stays < Q with no subtraction.
//   Double step: t = r<<1 (W+1 bits);  r <= (t >= Q) ? t - Q : t.
//   DONE: out_valid=1; out_y=r and out_tag=tag are held stable until out_ready=1.
//     out_ready=1, no accept in the same cycle -> IDLE.
//     out_ready=1 and accept in the same cycle -> load the new operand (BUSY or DONE).
//       There is no bubble between results.
//   Latency: accept edge to out_valid high = 1 + k cycles. Throughput = one result per (1 + k) cycles.
//   out_y and out_tag change only on the transition into DONE.
//     Between results they keep their last value; out_valid is 0 outside DONE.
//   in_k > KMAX: the result is undefined. The FSM must still return to IDLE/DONE within 2^KW cycles.
//   x = 0 yields 0 for any k and dir.
//   in_x >= 2*Q: the result is undefined.
// TESTING
//   1. in_x=1, k=1, dir=0 -> out_y=1665; out_valid 2 cycles after accept; tag echoed.
//   2. in_x=3, k=7, dir=0 -> out_y=3251 (3*128^-1 mod 3329) after 8 cycles.
//      Follow with in_x=3251, k=7, dir=1 -> out_y=3.
//   3. in_x=3330, k=0 -> out_y=1 after 1 cycle. in_x=3328, k=1, dir=1 -> out_y=3327.
//   4. Hold out_ready=0 for 5 cycles in DONE -> out_y/out_tag stable, in_ready=0.
//      Then out_ready=1 with in_valid=1 -> new operand accepted in the same cycle, no idle cycle.
//   5. Assert rst during BUSY (k=7, step 3) -> next cycle out_valid=0, out_y=0, busy=0.
//      After rst drops, in_ready=1 and a fresh op completes correctly.
//   6. Random sweep of all x in [0,2Q), k in 0..7, both dirs, random out_ready
//      -> matches the reference model x*2^(+/-k) mod Q; no lost or duplicated results.

Source files
------------

// File: rtl/mod_pow2_scale_seq.sv
// Iterative modular power-of-two scaler: y = x * 2^(-k) mod Q (halve) or x * 2^k mod Q (double).
// One halving/doubling step per clock, valid/ready on both sides, tag carried alongside.
module mod_pow2_scale_seq #(
    parameter int Q    = 3329,
    parameter int W    = 12,
    parameter int KMAX = 7,
    parameter int KW   = 3,
    parameter int TW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [KW-1:0] in_k,
    input  logic          in_dir,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_y,
    output logic [TW-1:0] out_tag,
    output logic          busy
);

    localparam logic [W-1:0]  Q_W    = W'(Q);
    localparam logic [W:0]    Q_W1   = (W+1)'(Q);
    localparam logic [W-1:0]  HALF_W = W'((Q + 1) / 2);
    localparam logic [KW-1:0] KMAX_W = KW'(KMAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   r_q, r_d;
    logic [KW-1:0]  cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic [TW-1:0]  tag_q, tag_d;
    logic [W-1:0]   y_q, y_d;
    logic [TW-1:0]  ytag_q, ytag_d;

    logic           accept_s;
    logic [W-1:0]   in_r_s;
    logic [W-1:0]   step_s;
    logic [KW-1:0]  k_eff_s;

    function automatic logic [W-1:0] reduce_once(input logic [W-1:0] x);
        logic [W-1:0] res;
        if (x >= Q_W) res = x - Q_W;
        else          res = x;
        return res;
    endfunction

    // Odd r: (r + Q) / 2 rewritten as (r >> 1) + (Q + 1) / 2 so it never leaves [0, Q).
    function automatic logic [W-1:0] halve_step(input logic [W-1:0] r);
        logic [W-1:0] res;
        if (r[0]) res = (r >> 1) + HALF_W;
        else      res = r >> 1;
        return res;
    endfunction

    function automatic logic [W-1:0] double_step(input logic [W-1:0] r);
        logic [W:0] t;
        logic [W:0] ts;
        t  = {r, 1'b0};
        ts = t - Q_W1;
        if (t >= Q_W1) return ts[W-1:0];
        else           return t[W-1:0];
    endfunction

    assign accept_s  = in_valid & in_ready;
    assign in_r_s    = reduce_once(in_x);
    assign step_s    = dir_q ? double_step(r_q) : halve_step(r_q);
    // Out-of-range step counts are clamped so the FSM always terminates.
    assign k_eff_s   = (in_k > KMAX_W) ? KMAX_W : in_k;

    assign in_ready  = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out_y     = y_q;
    assign out_tag   = ytag_q;

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        tag_d   = tag_q;
        y_d     = y_q;
        ytag_d  = ytag_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = (k_eff_s == {KW{1'b0}}) ? S_DONE : S_BUSY;
                else          state_d = S_IDLE;
            end
            S_BUSY: begin
                r_d   = step_s;
                cnt_d = cnt_q - KW'(1);
                if (cnt_q <= KW'(1)) begin
                    state_d = S_DONE;
                    y_d     = step_s;
                    ytag_d  = tag_q;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (accept_s)       state_d = (k_eff_s == {KW{1'b0}}) ? S_DONE : S_BUSY;
                else if (out_ready) state_d = S_IDLE;
                else                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept_s) begin
            r_d   = in_r_s;
            cnt_d = k_eff_s;
            dir_d = in_dir;
            tag_d = in_tag;
            if (k_eff_s == {KW{1'b0}}) begin
                y_d    = in_r_s;
                ytag_d = in_tag;
            end else begin
                y_d    = y_q;
                ytag_d = ytag_q;
            end
        end else begin
            dir_d = dir_q;
        end
    end

    // State and datapath registers; reset discards any in-flight operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= {W{1'b0}};
            cnt_q   <= {KW{1'b0}};
            dir_q   <= 1'b0;
            tag_q   <= {TW{1'b0}};
            y_q     <= {W{1'b0}};
            ytag_q  <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            tag_q   <= tag_d;
            y_q     <= y_d;
            ytag_q  <= ytag_d;
        end
    end

endmodule
